// File: rtl/result_display_driver_if.sv
// Result bus between the calculator controller and the display driver.
//   value : 16-bit result word (controller -> driver)
//   start : capture/convert request (controller -> driver)
//   busy  : conversion in progress (driver -> controller)
//   done  : one-cycle pulse, new digits valid (driver -> controller)
//   neg   : registered sign of the displayed value
//   bcd   : registered digits, [3:0] ones .. [19:16] ten-thousands
//   blank : leading-zero mask per digit, bit0 always 0
// Handshake: start is sampled on a rising edge only while busy is low; a
// start seen while busy is high is dropped. done is high for exactly one
// cycle, and neg/bcd/blank are valid from that cycle until the next done.
interface result_display_driver_if;
    logic [15:0] value;
    logic        start;
    logic        busy;
    logic        done;
    logic        neg;
    logic [19:0] bcd;
    logic [4:0]  blank;

    modport master (
        output value, start,
        input  busy, done, neg, bcd, blank
    );

    modport slave (
        input  value, start,
        output busy, done, neg, bcd, blank
    );
endinterface

// File: rtl/result_display_driver.sv
// Captures a 16-bit result on start, converts its magnitude to five BCD
// digits with a sequential double-dabble engine, computes leading-zero
// blanking, and multiplexes a 6-position common-anode seven-segment display
// (sign position plus five digits).
// Ports:
//   clk   : system clock
//   RST   : asynchronous, active-high reset
//   bus   : result bus (slave side), see result_display_driver_if
//   seg   : segment drive {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an    : position enable, one-hot active-low; an[0]=ones, an[5]=sign
//   state : current conversion FSM state (debug)
module result_display_driver #(
    parameter int SIGN_MAG       = 1,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    RST,
    result_display_driver_if.slave  bus,
    output logic [6:0]              seg,
    output logic [5:0]              an,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      cur_state, next_state;
    logic [15:0] cap;
    logic [15:0] mag;
    logic [15:0] load_mag;
    logic [19:0] scratch;
    logic [19:0] adj;
    logic [19:0] shift_scratch;
    logic [4:0]  iter;
    logic        sign;
    logic        nonzero;
    logic [19:0] bcd_q;
    logic        neg_q;
    logic [4:0]  blank_q;

    // Bit i set iff digits i..4 are all zero; the ones digit is never blanked.
    function automatic logic [4:0] blank_of(input logic [19:0] d);
        logic [4:0] b;
        b[4] = (d[19:16] == 4'd0);
        b[3] = b[4] && (d[15:12] == 4'd0);
        b[2] = b[3] && (d[11:8] == 4'd0);
        b[1] = b[2] && (d[7:4] == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) cur_state <= IDLE;
        else     cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (bus.start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (iter == 5'd15) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign state    = cur_state;
    assign bus.busy = (cur_state != IDLE);
    assign bus.done = (cur_state == DONE);

    // ---------------- datapath ----------------
    // Two's complement negation wraps 0x8000 to itself, which read as
    // unsigned is 32768, exactly the magnitude wanted.
    always_comb begin
        if (SIGN_MAG != 0) load_mag = {1'b0, cap[14:0]};
        else if (cap[15])  load_mag = ~cap + 16'd1;
        else               load_mag = cap;
    end

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign shift_scratch = {adj[18:0], mag[15]};

    // The published registers are written on the edge that ends the last
    // shift, so they are already valid in the DONE cycle alongside done.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cap     <= 16'd0;
            mag     <= 16'd0;
            scratch <= 20'd0;
            iter    <= 5'd0;
            sign    <= 1'b0;
            nonzero <= 1'b0;
            bcd_q   <= 20'd0;
            neg_q   <= 1'b0;
            blank_q <= 5'b11110;
        end else begin
            case (cur_state)
                IDLE: if (bus.start) cap <= bus.value;
                LOAD: begin
                    mag     <= load_mag;
                    sign    <= cap[15];
                    nonzero <= (load_mag != 16'd0);
                    scratch <= 20'd0;
                    iter    <= 5'd0;
                end
                SHIFT: begin
                    scratch <= shift_scratch;
                    mag     <= {mag[14:0], 1'b0};
                    iter    <= iter + 5'd1;
                    if (iter == 5'd15) begin
                        bcd_q   <= shift_scratch;
                        neg_q   <= sign & nonzero;
                        blank_q <= blank_of(shift_scratch);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.neg   = neg_q;
    assign bus.blank = blank_q;

    // ---------------- display scan ----------------
    logic [15:0] scan_cnt;
    logic [2:0]  pos;
    logic [3:0]  cur_digit;
    logic        cur_blank;
    logic [6:0]  pattern;
    logic [6:0]  drive;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            scan_cnt <= 16'd0;
            pos      <= 3'd0;
        end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
            scan_cnt <= 16'd0;
            pos      <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        pattern   = 7'h00;
        case (pos)
            3'd0: begin cur_digit = bcd_q[3:0];   cur_blank = blank_q[0]; end
            3'd1: begin cur_digit = bcd_q[7:4];   cur_blank = blank_q[1]; end
            3'd2: begin cur_digit = bcd_q[11:8];  cur_blank = blank_q[2]; end
            3'd3: begin cur_digit = bcd_q[15:12]; cur_blank = blank_q[3]; end
            3'd4: begin cur_digit = bcd_q[19:16]; cur_blank = blank_q[4]; end
            default: ;
        endcase
        if (pos == 3'd5)     pattern = neg_q ? 7'h40 : 7'h00;
        else if (!cur_blank) pattern = digit_pattern(cur_digit);
        drive = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
    end

    // seg and an come from the same pos in the same register stage so a
    // position enable never pairs with another position's segments. The
    // reset pattern is the ones digit showing "0".
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            an  <= 6'b111110;
            seg <= (SEG_ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;
        end else begin
            an  <= ~(6'b000001 << pos);
            seg <= drive;
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
module tb_result_display_driver;

    logic clk;
    logic rst;

    result_display_driver_if bus_sm ();
    result_display_driver_if bus_tc ();

    logic [6:0] seg_sm, seg_tc;
    logic [5:0] an_sm, an_tc;
    logic [1:0] state_sm, state_tc;

    result_display_driver #(.SIGN_MAG(1), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) u_sm (
        .clk(clk), .RST(rst), .bus(bus_sm), .seg(seg_sm), .an(an_sm), .state(state_sm)
    );

    result_display_driver #(.SIGN_MAG(0), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) u_tc (
        .clk(clk), .RST(rst), .bus(bus_tc), .seg(seg_tc), .an(an_tc), .state(state_tc)
    );

    // index 0 = sign-magnitude instance, index 1 = two's complement instance
    logic        done_v[2];
    logic        busy_v[2];
    logic        neg_v[2];
    logic [19:0] bcd_v[2];
    logic [4:0]  blank_v[2];
    logic [6:0]  seg_v[2];
    logic [5:0]  an_v[2];

    assign done_v[0]  = bus_sm.done;   assign done_v[1]  = bus_tc.done;
    assign busy_v[0]  = bus_sm.busy;   assign busy_v[1]  = bus_tc.busy;
    assign neg_v[0]   = bus_sm.neg;    assign neg_v[1]   = bus_tc.neg;
    assign bcd_v[0]   = bus_sm.bcd;    assign bcd_v[1]   = bus_tc.bcd;
    assign blank_v[0] = bus_sm.blank;  assign blank_v[1] = bus_tc.blank;
    assign seg_v[0]   = seg_sm;        assign seg_v[1]   = seg_tc;
    assign an_v[0]    = an_sm;         assign an_v[1]    = an_tc;

    int total = 0;
    int bad   = 0;
    logic [25:0] exp_q[$];   // {neg, blank[4:0], bcd[19:0]}

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [25:0] model(input bit sm, input logic [15:0] v);
        logic [15:0] m16;
        int          m;
        int          p;
        logic [19:0] b;
        logic [4:0]  bl;
        logic        n;
        if (sm)         m16 = {1'b0, v[14:0]};
        else if (v[15]) m16 = 16'(17'h10000 - {1'b0, v});
        else            m16 = v;
        m = int'(m16);
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        bl[0] = 1'b0;
        p = 10;
        for (int i = 1; i < 5; i++) begin
            bl[i] = (int'(m16) < p);
            p = p * 10;
        end
        n = v[15] && (m16 != 16'd0);
        return {n, bl, b};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input int d, input logic s, input logic [15:0] v);
        if (d == 0) begin bus_sm.start = s; bus_sm.value = v; end
        else        begin bus_tc.start = s; bus_tc.value = v; end
    endtask

    // Drives one start pulse, optionally a second pulse mid-conversion, then
    // waits for done and checks latency, output stability and the scoreboard.
    task automatic run_conv(input int d, input logic [15:0] v, input int retrig_at,
                            input logic [15:0] v2, input string name);
        logic [25:0] prev, got, expv;
        bit          seen;
        bit          moved;
        int          lat;
        exp_q.push_back(model(d == 0, v));
        prev  = {neg_v[d], blank_v[d], bcd_v[d]};
        seen  = 0;
        moved = 0;
        lat   = 0;
        @(negedge clk);
        set_in(d, 1'b1, v);
        @(posedge clk);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) set_in(d, 1'b0, 16'h0000);
            if (retrig_at > 0 && n == retrig_at)     set_in(d, 1'b1, v2);
            if (retrig_at > 0 && n == retrig_at + 1) set_in(d, 1'b0, 16'h0000);
            if (done_v[d]) begin
                seen = 1;
                lat  = n;
            end else if ({neg_v[d], blank_v[d], bcd_v[d]} !== prev) begin
                moved = 1;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout: no done within 40 cycles", name);
            void'(exp_q.pop_front());
        end else begin
            got  = {neg_v[d], blank_v[d], bcd_v[d]};
            expv = exp_q.pop_front();
            if (got !== expv) begin
                bad++;
                $display("FAIL %s result: got neg=%0b blank=%b bcd=%h, want neg=%0b blank=%b bcd=%h",
                         name, got[25], got[24:20], got[19:0], expv[25], expv[24:20], expv[19:0]);
            end
            total++;
            if (lat !== 18) begin
                bad++;
                $display("FAIL %s latency: got %0d cycles, want 18", name, lat);
            end
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL %s stability: outputs changed before done", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 1'b0, 16'h0000);
        set_in(1, 1'b0, 16'h0000);
        #7;
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
        total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_v[0]); end
        total++; if (neg_v[0] !== 1'b0) begin bad++; $display("FAIL reset_neg: got %b want 0", neg_v[0]); end
        total++; if (bcd_v[0] !== 20'h00000) begin bad++; $display("FAIL reset_bcd: got %h want 00000", bcd_v[0]); end
        total++; if (blank_v[0] !== 5'b11110) begin bad++; $display("FAIL reset_blank: got %b want 11110", blank_v[0]); end
        total++; if (an_v[0] !== 6'b111110) begin bad++; $display("FAIL reset_an: got %b want 111110", an_v[0]); end
        total++; if (seg_v[0] !== 7'h40) begin bad++; $display("FAIL reset_seg: got %h want 40", seg_v[0]); end
        total++; if (an_v[1] !== 6'b111110) begin bad++; $display("FAIL reset_an_tc: got %b want 111110", an_v[1]); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sm_34();
        logic [5:0] pos_an[4];
        logic [6:0] pos_seg[4];
        bit ok;
        run_conv(0, 16'h0022, 0, 16'h0000, "sm_34");
        total++;
        if (bcd_v[0] !== 20'h00034 || blank_v[0] !== 5'b11100) begin
            bad++;
            $display("FAIL sm_34_const: got bcd=%h blank=%b want 00034 11100", bcd_v[0], blank_v[0]);
        end
        pos_an[0] = 6'b111110; pos_seg[0] = ~7'h66;   // ones: 4
        pos_an[1] = 6'b111101; pos_seg[1] = ~7'h4F;   // tens: 3
        pos_an[2] = 6'b110111; pos_seg[2] = ~7'h00;   // thousands: blanked
        pos_an[3] = 6'b011111; pos_seg[3] = ~7'h00;   // sign: positive
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int n = 0; n < 80 && !ok; n++) begin
                @(negedge clk);
                if (an_v[0] === pos_an[k]) ok = 1;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL sm_34_scan%0d: an never reached %b", k, pos_an[k]);
            end else if (seg_v[0] !== pos_seg[k]) begin
                bad++;
                $display("FAIL sm_34_scan%0d: an=%b seg got %h want %h", k, pos_an[k], seg_v[0], pos_seg[k]);
            end
        end
    endtask

    task automatic test_tc_8000();
        bit ok;
        run_conv(1, 16'h8000, 0, 16'h0000, "tc_8000");
        total++;
        if (bcd_v[1] !== 20'h32768 || neg_v[1] !== 1'b1 || blank_v[1] !== 5'b00000) begin
            bad++;
            $display("FAIL tc_8000_const: got bcd=%h neg=%b blank=%b want 32768 1 00000",
                     bcd_v[1], neg_v[1], blank_v[1]);
        end
        ok = 0;
        for (int n = 0; n < 80 && !ok; n++) begin
            @(negedge clk);
            if (an_v[1] === 6'b011111) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tc_8000_sign: an never reached 011111");
        end else if (seg_v[1] !== ~7'h40) begin
            bad++;
            $display("FAIL tc_8000_sign: seg got %h want %h", seg_v[1], ~7'h40);
        end
    endtask

    task automatic test_sm_neg_zero();
        run_conv(0, 16'h8000, 0, 16'h0000, "sm_neg_zero");
        total++;
        if (bcd_v[0] !== 20'h00000 || neg_v[0] !== 1'b0 || blank_v[0] !== 5'b11110) begin
            bad++;
            $display("FAIL sm_neg_zero_const: got bcd=%h neg=%b blank=%b want 00000 0 11110",
                     bcd_v[0], neg_v[0], blank_v[0]);
        end
    endtask

    task automatic test_retrigger();
        int extra;
        run_conv(0, 16'h0987, 5, 16'h0111, "retrigger");
        extra = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done_v[0]) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL retrigger_extra_done: got %0d extra done pulses want 0", extra);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL retrigger_queue: %0d expectations left want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] got, expv;
        bit seen;
        int gap;
        exp_q.push_back(model(0, 16'hFFFF));
        exp_q.push_back(model(0, 16'h2710));
        @(negedge clk);
        set_in(1, 1'b1, 16'hFFFF);
        for (int r = 0; r < 2; r++) begin
            seen = 0;
            gap  = 0;
            for (int n = 1; n <= 45 && !seen; n++) begin
                @(negedge clk);
                if (done_v[1]) begin seen = 1; gap = n; end
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL b2b_%0d timeout: no done within 45 cycles", r);
                void'(exp_q.pop_front());
            end else begin
                got  = {neg_v[1], blank_v[1], bcd_v[1]};
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    bad++;
                    $display("FAIL b2b_%0d result: got %h want %h", r, got, expv);
                end
                if (r == 1) begin
                    total++;
                    if (gap !== 19) begin
                        bad++;
                        $display("FAIL b2b_gap: got %0d cycles between done pulses want 19", gap);
                    end
                end
            end
            if (r == 0) set_in(1, 1'b1, 16'h2710);
            else        set_in(1, 1'b0, 16'h0000);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_in(0, 1'b1, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 16'h0000);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || neg_v[0] !== 1'b0 ||
            bcd_v[0] !== 20'h00000 || blank_v[0] !== 5'b11110 ||
            an_v[0] !== 6'b111110 || seg_v[0] !== 7'h40) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b neg=%b bcd=%h blank=%b an=%b seg=%h want 0 0 0 00000 11110 111110 40",
                     busy_v[0], done_v[0], neg_v[0], bcd_v[0], blank_v[0], an_v[0], seg_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        run_conv(0, 16'h7FFF, 0, 16'h0000, "after_reset_7fff");
        total++;
        if (bcd_v[0] !== 20'h32767) begin
            bad++;
            $display("FAIL after_reset_const: got bcd=%h want 32767", bcd_v[0]);
        end
    endtask

    task automatic test_scan_dwell();
        bit ok;
        int dwell;
        ok = 0;
        for (int n = 0; n < 80 && !ok; n++) begin
            @(negedge clk);
            if (an_v[0] === 6'b011111) ok = 1;
        end
        if (ok) begin
            ok = 0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (an_v[0] === 6'b111110) ok = 1;
            end
        end
        dwell = 0;
        if (ok) begin
            dwell = 1;
            for (int n = 0; n < 20 && an_v[0] === 6'b111110; n++) begin
                @(negedge clk);
                if (an_v[0] === 6'b111110) dwell++;
            end
        end
        total++;
        if (dwell !== 4) begin
            bad++;
            $display("FAIL scan_dwell: got %0d cycles per position want 4", dwell);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 6; k++) begin
            v = 16'($urandom_range(0, 65535));
            run_conv(k % 2, v, 0, 16'h0000, (k % 2 == 0) ? "rand_sm" : "rand_tc");
        end
    endtask

    initial begin
        test_reset();
        test_sm_34();
        test_tc_8000();
        test_sm_neg_zero();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_scan_dwell();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
